pipeline_register_file: RTL and testbench

Parametrised multi-port register file for the pipelined CPU datapath: 2 combinational read ports, 2 synchronous write ports with byte enables, write-to-read bypass, and a per-register busy scoreboard with flush. Sits in decode (reads and busy checks) and writeback (writes and busy clears). It replaces the single-write, fixed-width register file of the single-cycle core.

---
 rtl/pipeline_register_file.sv | 128 ++++++++++++
 tb/tb_pipeline_register_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register_file.sv
// Multi-port register file: two combinational read ports, two byte-enabled write
// ports with write-to-read bypass, and a per-register busy scoreboard with flush.
module pipeline_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rd0_addr,
  output logic [DATA_W-1:0]   rd0_data,
  output logic                rd0_busy,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  output logic                rd1_busy,
  input  logic                wr0_en,
  input  logic [ADDR_W-1:0]   wr0_addr,
  input  logic [DATA_W-1:0]   wr0_data,
  input  logic [DATA_W/8-1:0] wr0_be,
  input  logic                wr0_clr,
  input  logic                wr1_en,
  input  logic [ADDR_W-1:0]   wr1_addr,
  input  logic [DATA_W-1:0]   wr1_data,
  input  logic [DATA_W/8-1:0] wr1_be,
  input  logic                wr1_clr,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                flush,
  output logic [ADDR_W:0]     busy_count
);

  localparam int NB       = DATA_W / 8;
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic [ADDR_W:0]     busy_count_q, busy_count_d;
  logic [ADDR_W:0]     dec;
  logic                inc;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] data,
                                              input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = base;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // wr1 is applied after wr0 so it wins on overlapping bytes.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    if (BYPASS != 0) begin
      if (wr0_en && wr0_addr == a) v = merge(v, wr0_data, wr0_be);
      if (wr1_en && wr1_addr == a) v = merge(v, wr1_data, wr1_be);
    end
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr0_en && wr0_addr == ADDR_W'(i)) regs_d[i] = merge(regs_d[i], wr0_data, wr0_be);
      if (wr1_en && wr1_addr == ADDR_W'(i)) regs_d[i] = merge(regs_d[i], wr1_data, wr1_be);
      if (ZERO_REG != 0 && i == 0) regs_d[i] = '0;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr0_en && wr0_clr && wr0_addr == ADDR_W'(i)) clr_vec[i] = 1'b1;
      if (wr1_en && wr1_clr && wr1_addr == ADDR_W'(i)) clr_vec[i] = 1'b1;
      if (iss_valid && !flush && iss_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0))
        set_vec[i] = 1'b1;
    end
  end

  // A clear only decrements when the register was busy and is not re-issued.
  always_comb begin
    inc = |(set_vec & ~busy_q);
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      dec = dec + {{ADDR_W{1'b0}}, clr_vec[i] & busy_q[i] & ~set_vec[i]};
    if (flush) begin
      busy_d       = '0;
      busy_count_d = '0;
    end else begin
      busy_d       = (busy_q & ~clr_vec) | set_vec;
      busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, inc} - dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    rd0_data = rd_val(rd0_addr);
    rd1_data = rd_val(rd1_addr);
    rd0_busy = busy_q[rd0_addr];
    rd1_busy = busy_q[rd1_addr];
    if (BYPASS != 0) begin
      if (clr_vec[rd0_addr]) rd0_busy = 1'b0;
      if (clr_vec[rd1_addr]) rd1_busy = 1'b0;
    end
    if (ZERO_REG != 0 && rd0_addr == '0) rd0_busy = 1'b0;
    if (ZERO_REG != 0 && rd1_addr == '0) rd1_busy = 1'b0;
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_pipeline_register_file.sv
// Self-checking bench: directed vector table, async reset sequence, then random
// traffic compared against an array-based reference model.
module tb_pipeline_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd0_addr, rd1_addr, wr0_addr, wr1_addr, iss_addr;
  logic [31:0] rd0_data, rd1_data, wr0_data, wr1_data;
  logic        rd0_busy, rd1_busy, wr0_en, wr1_en, wr0_clr, wr1_clr, iss_valid, flush;
  logic [3:0]  wr0_be, wr1_be;
  logic [5:0]  busy_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_register_file dut (
    .clk(clk), .rst(rst),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_busy(rd0_busy),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_busy(rd1_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be), .wr0_clr(wr0_clr),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be), .wr1_clr(wr1_clr),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush), .busy_count(busy_count)
  );

  typedef struct {
    logic w0e; logic [4:0] w0a; logic [31:0] w0d; logic [3:0] w0b; logic w0c;
    logic w1e; logic [4:0] w1a; logic [31:0] w1d; logic [3:0] w1b; logic w1c;
    logic iv;  logic [4:0] ia;  logic fl;
    logic [4:0] r0a; logic [4:0] r1a;
    logic [31:0] e0; logic [31:0] e1; logic eb0; logic eb1; logic [5:0] ecnt;
  } vec_t;

  // Reference model: plain storage plus a busy set.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return 32'h0;
    r = m_mem[a];
    for (int b = 0; b < 4; b++) begin
      if (v.w1e && v.w1a == a && v.w1b[b]) r[8*b +: 8] = v.w1d[8*b +: 8];
      else if (v.w0e && v.w0a == a && v.w0b[b]) r[8*b +: 8] = v.w0d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic m_rbusy(input vec_t v, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (v.w0e && v.w0c && v.w0a == a) return 1'b0;
    if (v.w1e && v.w1c && v.w1a == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic m_update(input vec_t v);
    logic [31:0] nxt [32];
    for (int i = 0; i < 32; i++) nxt[i] = m_read(v, 5'(i));
    for (int i = 0; i < 32; i++) m_mem[i] = nxt[i];
    if (v.fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (v.w0e && v.w0c) m_busy[v.w0a] = 0;
      if (v.w1e && v.w1c) m_busy[v.w1a] = 0;
      if (v.iv && v.ia != 0) m_busy[v.ia] = 1;
    end
  endtask

  task automatic drive(input vec_t v);
    wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d; wr0_be = v.w0b; wr0_clr = v.w0c;
    wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d; wr1_be = v.w1b; wr1_clr = v.w1c;
    iss_valid = v.iv; iss_addr = v.ia; flush = v.fl;
    rd0_addr = v.r0a; rd1_addr = v.r1a;
  endtask

  // Called at a negedge; use_tab selects table expectations over the model.
  task automatic step(input vec_t v, input bit use_tab, input string tag);
    drive(v);
    #1;
    if (use_tab) begin
      chk({tag, " rd0_data"}, rd0_data, v.e0);
      chk({tag, " rd1_data"}, rd1_data, v.e1);
      chk({tag, " rd0_busy"}, 32'(rd0_busy), 32'(v.eb0));
      chk({tag, " rd1_busy"}, 32'(rd1_busy), 32'(v.eb1));
    end else begin
      chk({tag, " rd0_data"}, rd0_data, m_read(v, v.r0a));
      chk({tag, " rd1_data"}, rd1_data, m_read(v, v.r1a));
      chk({tag, " rd0_busy"}, 32'(rd0_busy), 32'(m_rbusy(v, v.r0a)));
      chk({tag, " rd1_busy"}, 32'(rd1_busy), 32'(m_rbusy(v, v.r1a)));
    end
    @(posedge clk);
    #1;
    m_update(v);
    chk({tag, " busy_count"}, 32'(busy_count), use_tab ? 32'(v.ecnt) : 32'(m_count()));
    @(negedge clk);
  endtask

  vec_t idle;
  vec_t tab [];
  vec_t v;

  initial begin
    idle = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0};
    tab = new[21];
    //        w0e a  data          be   c   w1e a  data          be   c   iv ia fl  r0 r1  e0            e1            b0 b1 cnt
    tab[0]  = '{1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 5, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0};
    tab[1]  = '{0, 0, 32'h0,        4'h0, 0, 1, 5, 32'h000000AA, 4'h1, 0, 0, 0, 0, 5, 7,  32'hDEADBEAA, 32'h0,        0, 0, 0};
    tab[2]  = '{1, 0, 32'h12345678, 4'hF, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 0, 5,  32'h0,        32'hDEADBEAA, 0, 0, 0};
    tab[3]  = '{1, 7, 32'h11111111, 4'hF, 0, 1, 7, 32'h22222222, 4'h3, 0, 0, 0, 0, 7, 0,  32'h11112222, 32'h0,        0, 0, 0};
    tab[4]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 3, 0, 7, 3,  32'h11112222, 32'h0,        0, 0, 1};
    tab[5]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 4, 0, 3, 4,  32'h0,        32'h0,        1, 0, 2};
    tab[6]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 3, 0, 3, 4,  32'h0,        32'h0,        1, 1, 2};
    tab[7]  = '{1, 3, 32'hFFFFFFFF, 4'h0, 1, 1, 4, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0, 3, 4,  32'h0,        32'h0,        0, 0, 0};
    tab[8]  = '{1, 9, 32'h0,        4'h0, 1, 0, 0, 32'h0,        4'h0, 0, 1, 9, 0, 9, 3,  32'h0,        32'h0,        0, 0, 1};
    tab[9]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 9, 3,  32'h0,        32'h0,        1, 0, 1};
    tab[10] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 1, 0, 1, 9,  32'h0,        32'h0,        0, 1, 2};
    tab[11] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 2, 0, 9, 1,  32'h0,        32'h0,        1, 1, 3};
    tab[12] = '{0, 0, 32'h0,        4'h0, 0, 1, 9, 32'h0,        4'h0, 1, 1, 6, 0, 9, 6,  32'h0,        32'h0,        0, 0, 3};
    tab[13] = '{1, 8, 32'hAABBCCDD, 4'hF, 0, 0, 0, 32'h0,        4'h0, 0, 1, 8, 1, 2, 8,  32'h0,        32'hAABBCCDD, 1, 0, 0};
    tab[14] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 8, 1,  32'hAABBCCDD, 32'h0,        0, 0, 0};
    tab[15] = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 0, 7,  32'h0,        32'h11112222, 0, 0, 0};
    tab[16] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        4'h0, 0, 1,10, 0,10, 5,  32'h0,        32'hDEADBEAA, 0, 0, 1};
    tab[17] = '{1,10, 32'h0,        4'h0, 1, 0, 0, 32'h0,        4'h0, 0, 1,10, 0,10,10,  32'h0,        32'h0,        0, 0, 1};
    tab[18] = '{1,10, 32'h0,        4'h0, 1, 1,10, 32'h0,        4'h0, 1, 0, 0, 0,10, 9,  32'h0,        32'h0,        0, 0, 0};
    tab[19] = '{1,12, 32'h12345678, 4'h5, 0, 1,12, 32'hAABBCCDD, 4'h6, 0, 0, 0, 0,12,12,  32'h00BBCC78, 32'h00BBCC78, 0, 0, 0};
    tab[20] = '{1,11, 32'h0,        4'h0, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0,12,11,  32'h00BBCC78, 32'h0,        0, 0, 0};

    drive(idle);
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd0_addr = 5'(i);
      rd1_addr = 5'(31 - i);
      #1;
      chk("reset rd", {rd0_data | rd1_data}, 32'h0);
      chk("reset busy", 32'({rd0_busy, rd1_busy}), 32'h0);
      @(negedge clk);
    end
    chk("reset busy_count", 32'(busy_count), 32'h0);

    for (int i = 0; i < 21; i++) step(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset arriving mid-cycle.
    v = idle;
    v.w0e = 1; v.w0a = 5; v.w0d = 32'hDEADBEAA; v.w0b = 4'hF;
    v.iv = 1; v.ia = 3; v.r0a = 5; v.r1a = 3;
    step(v, 1'b0, "pre_rst");
    v = idle; v.r0a = 5; v.r1a = 3;
    drive(v);
    #1;
    chk("pre_rst r5", rd0_data, 32'hDEADBEAA);
    chk("pre_rst r3 busy", 32'(rd1_busy), 32'h1);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst r5", rd0_data, 32'h0);
    chk("async_rst busy_count", 32'(busy_count), 32'h0);
    chk("async_rst r3 busy", 32'(rd1_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      v.w0e = 1'($urandom);  v.w0a = 5'($urandom_range(0, 7)); v.w0d = $urandom;
      v.w0b = 4'($urandom);  v.w0c = 1'($urandom);
      v.w1e = 1'($urandom);  v.w1a = 5'($urandom_range(0, 7)); v.w1d = $urandom;
      v.w1b = 4'($urandom);  v.w1c = ($urandom_range(0, 3) == 0);
      v.iv  = ($urandom_range(0, 3) != 0); v.ia = 5'($urandom_range(0, 9));
      v.fl  = ($urandom_range(0, 23) == 0);
      v.r0a = 5'($urandom_range(0, 9)); v.r1a = 5'($urandom_range(0, 9));
      step(v, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
